// File: rtl/kmp_stream_matcher.sv
// Streaming Knuth-Morris-Pratt matcher: loads a pattern, builds its failure table in
// hardware, then scans a valid/ready text stream and reports every (overlapping) match.
module kmp_stream_matcher #(
  parameter int CHAR_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pat_valid,
  input  logic [CHAR_W-1:0] pat_char,
  input  logic              pat_last,
  output logic              pat_ready,
  input  logic              text_valid,
  input  logic [CHAR_W-1:0] text_char,
  input  logic              text_last,
  output logic              text_ready,
  output logic              match_valid,
  output logic [POS_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_count,
  output logic              pat_ovf,
  output logic              done
);
  localparam int LW = $clog2(PAT_MAX + 1);
  localparam int IW = $clog2(PAT_MAX);
  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] LEN_MAX = LW'(PAT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BUILD = 3'd2,
    S_MATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d, i_q, i_d, k_q, k_d, j_q, j_d;
  logic [POS_W-1:0]    tidx_q, tidx_d, mpos_q, mpos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d, held_q, held_d, hlast_q, hlast_d, mv_q, mv_d;
  logic [CHAR_W-1:0]   hchar_q, hchar_d;
  logic [CHAR_W-1:0]   pat_q  [PAT_MAX];
  logic [LW-1:0]       fail_q [PAT_MAX];

  logic                pat_we_s, fail_we_s, consume_s;
  logic [IW-1:0]       fail_wa_s;
  logic [LW-1:0]       fail_wd_s, nlen_s;
  logic [IW-1:0]       pi_s, pk_s, pkm1_s, pj_s, pjm1_s, plm1_s;

  // Array indices narrowed to the table address width; only used while in range.
  assign pi_s   = IW'(i_q);
  assign pk_s   = IW'(k_q);
  assign pkm1_s = IW'(k_q - ONE);
  assign pj_s   = IW'(j_q);
  assign pjm1_s = IW'(j_q - ONE);
  assign plm1_s = IW'(len_q - ONE);

  assign pat_ready   = (state_q == S_LOAD);
  assign text_ready  = (state_q == S_MATCH) && !held_q;
  assign match_valid = mv_q;
  assign match_pos   = mpos_q;
  assign match_count = cnt_q;
  assign pat_ovf     = ovf_q;
  assign done        = (state_q == S_DONE);

  // Next-state logic for the control FSM, pointers and table write enables.
  always_comb begin
    state_d = state_q;  len_d = len_q;   i_d = i_q;       k_d = k_q;     j_d = j_q;
    tidx_d  = tidx_q;   cnt_d = cnt_q;   ovf_d = ovf_q;   held_d = held_q;
    hchar_d = hchar_q;  hlast_d = hlast_q; mv_d = 1'b0;   mpos_d = mpos_q;
    pat_we_s = 1'b0;    fail_we_s = 1'b0; fail_wa_s = '0; fail_wd_s = '0;
    nlen_s = len_q;     consume_s = 1'b0;
    if (start) begin
      state_d = S_LOAD; len_d = '0; i_d = '0; k_d = '0; j_d = '0;
      tidx_d = '0; cnt_d = '0; ovf_d = 1'b0; held_d = 1'b0; hlast_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          if (pat_valid) begin
            if (len_q < LEN_MAX) begin
              pat_we_s = 1'b1;
              nlen_s   = len_q + ONE;
            end else begin
              ovf_d = 1'b1;
            end
            len_d = nlen_s;
            if (pat_last) begin
              fail_we_s = 1'b1;
              i_d = ONE; k_d = '0; j_d = '0;
              state_d = (nlen_s == ONE) ? S_MATCH : S_BUILD;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_BUILD: begin
          if (pat_q[pi_s] == pat_q[pk_s]) begin
            fail_we_s = 1'b1; fail_wa_s = pi_s; fail_wd_s = k_q + ONE;
            k_d = k_q + ONE;  i_d = i_q + ONE;
          end else if (k_q != '0) begin
            k_d = fail_q[pkm1_s];
          end else begin
            fail_we_s = 1'b1; fail_wa_s = pi_s; fail_wd_s = '0;
            i_d = i_q + ONE;
          end
          if (i_d == len_q) begin
            state_d = S_MATCH;
            j_d = '0;
          end else begin
            state_d = S_BUILD;
          end
        end
        S_MATCH: begin
          if (held_q) begin
            if (pat_q[pj_s] == hchar_q) begin
              consume_s = 1'b1;
              if (j_q == len_q - ONE) begin
                j_d = fail_q[plm1_s]; mv_d = 1'b1; mpos_d = tidx_q;
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
              end else begin
                j_d = j_q + ONE;
              end
            end else if (j_q != '0) begin
              j_d = fail_q[pjm1_s];
            end else begin
              consume_s = 1'b1;
            end
          end else if (text_valid) begin
            held_d = 1'b1; hchar_d = text_char; hlast_d = text_last;
          end else begin
            held_d = 1'b0;
          end
          if (consume_s) begin
            held_d  = 1'b0;
            tidx_d  = tidx_q + POS_W'(1);
            state_d = hlast_q ? S_DONE : S_MATCH;
          end else begin
            state_d = S_MATCH;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, pointer and table registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; len_q <= '0; i_q <= '0; k_q <= '0; j_q <= '0;
      tidx_q <= '0; mpos_q <= '0; cnt_q <= '0; ovf_q <= 1'b0; held_q <= 1'b0;
      hlast_q <= 1'b0; mv_q <= 1'b0; hchar_q <= '0;
      for (int n = 0; n < PAT_MAX; n++) begin
        pat_q[n]  <= '0;
        fail_q[n] <= '0;
      end
    end else begin
      state_q <= state_d; len_q <= len_d; i_q <= i_d; k_q <= k_d; j_q <= j_d;
      tidx_q <= tidx_d; mpos_q <= mpos_d; cnt_q <= cnt_d; ovf_q <= ovf_d; held_q <= held_d;
      hlast_q <= hlast_d; mv_q <= mv_d; hchar_q <= hchar_d;
      if (pat_we_s) pat_q[IW'(len_q)] <= pat_char;
      if (fail_we_s) fail_q[fail_wa_s] <= fail_wd_s;
    end
  end
endmodule
